// File: rtl/mem_pkg.sv
// mem_pkg: size/state encodings and alignment check for the load/store stage
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;
  typedef enum logic {IDLE, MERGE} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_RSVD || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/response handshake plus data-memory port of the load/store stage
interface mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: big-endian load lane extract/extend and sub-word store lane merge
module mem_lane_mux
  import mem_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sgn,
  input  logic [31:0] ld_word,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] lanes;
  always_comb begin
    b = ld_word[{~ld_off, 3'b000} +: 8];
    h = ld_word[{~ld_off[1], 4'b0000} +: 16];
    ld_data = ld_size == SZ_BYTE ? {{24{ld_sgn & b[7]}}, b}
            : ld_size == SZ_HALF ? {{16{ld_sgn & h[15]}}, h}
            : ld_word;
    mask  = st_size == SZ_BYTE ? 32'h0000_00ff << {~st_off, 3'b000}
          : st_size == SZ_HALF ? 32'h0000_ffff << {~st_off[1], 4'b0000}
          : 32'hffff_ffff;
    lanes = st_size == SZ_BYTE ? {4{st_data[7:0]}}
          : st_size == SZ_HALF ? {2{st_data[15:0]}}
          : st_data;
    merged = (st_word & ~mask) | (lanes & mask);
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store access stage with alignment checks and sub-word read-modify-write
module mem_stage
  import mem_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);
  state_t      state;
  logic [31:0] cap_word;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;
  logic        merge;
  logic        accept;
  logic        err;
  logic        sub;
  logic        rmw;
  logic [31:0] ld_data;
  logic [31:0] merged;
  mem_lane_mux lane (
    .ld_size (bus.req_size),
    .ld_off  (bus.req_addr[1:0]),
    .ld_sgn  (bus.req_signed),
    .ld_word (bus.mem_rdata),
    .st_size (cap_size),
    .st_off  (cap_addr[1:0]),
    .st_word (cap_word),
    .st_data (cap_wdata),
    .ld_data (ld_data),
    .merged  (merged)
  );
  always_comb begin
    merge         = rst_n && state == MERGE;
    bus.req_ready = rst_n && state == IDLE;
    accept        = bus.req_valid && bus.req_ready;
    err           = misaligned(bus.req_size, bus.req_addr[1:0]);
    sub           = bus.req_wr && bus.req_size != SZ_WORD;
    rmw           = accept && sub && !err;
    bus.mem_en    = merge || (accept && !err);
    bus.mem_wr    = merge || (accept && !err && bus.req_wr && !sub);
    bus.mem_addr  = !bus.mem_en ? '0 : merge ? {cap_addr[31:2], 2'b00} : {bus.req_addr[31:2], 2'b00};
    bus.mem_wdata = !bus.mem_wr ? '0 : merge ? merged : bus.req_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      cap_word      <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_size      <= '0;
    end else begin
      state         <= rmw ? MERGE : IDLE;
      bus.rsp_valid <= merge || (accept && !rmw);
      bus.rsp_err   <= accept && err;
      bus.rsp_rdata <= accept && !err && !bus.req_wr ? ld_data : '0;
      if (rmw) begin
        cap_word  <= bus.mem_rdata;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_size  <= bus.req_size;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench against a byte-array reference memory
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int bad_bus = 0;
  logic [31:0] mem [0:15];
  logic [7:0]  rb [0:63];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) wr_cnt++;
      else rd_cnt++;
    end
    if (bus.mem_en ? bus.mem_addr[1:0] != 2'b00 : (bus.mem_wr || bus.mem_addr != 0 || bus.mem_wdata != 0)) bad_bus++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int b;
    logic [7:0] v;
    logic [15:0] h;
    b = int'(a[5:0]);
    v = rb[b];
    if (sz == 2'd0) return sg ? {{24{v[7]}}, v} : {24'd0, v};
    h = {rb[b], rb[b+1]};
    if (sz == 2'd1) return sg ? {{16{h[15]}}, h} : {16'd0, h};
    return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
  endfunction
  function automatic logic [31:0] word_at(input int i);
    return {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]};
  endfunction
  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    int n;
    b = int'(a[5:0]);
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    for (int k = 0; k < n; k++) rb[b+k] = d[8*(n-1-k) +: 8];
  endtask
  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1;
    pl_idx = 4'(idx);
    pl_data = d;
    for (int k = 0; k < 4; k++) rb[4*idx+k] = d[8*(3-k) +: 8];
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask
  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_wr = wr;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_addr = a;
    bus.req_wdata = d;
  endtask
  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== word_at(i)) begin
        failures++;
        $display("FAIL %s mem[%0d] got=%h exp=%h", tag, i, mem[i], word_at(i));
      end
    end
  endtask
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    int r0;
    int w0;
    int n;
    logic e;
    logic sub;
    logic [31:0] exp;
    r0 = rd_cnt;
    w0 = wr_cnt;
    e = ref_err(sz, a);
    exp = (e || wr) ? 32'd0 : ref_load(sz, sg, a);
    sub = wr && !e && sz != 2'd2;
    drive(wr, sz, sg, a, d);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout ready=%b exp=1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!e && wr) ref_store(sz, a, d);
    if (sub) begin
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL merge_cycle valid=%b ready=%b exp 0 0", bus.rsp_valid, bus.req_ready);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e || bus.rsp_rdata !== exp) begin
      failures++;
      $display("FAIL rsp a=%h sz=%0d wr=%b got v=%b e=%b d=%h exp v=1 e=%b d=%h",
               a, sz, wr, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e, exp);
    end
    checks++;
    if (rd_cnt - r0 != ((!e && (!wr || sub)) ? 1 : 0) || wr_cnt - w0 != ((!e && wr) ? 1 : 0)) begin
      failures++;
      $display("FAIL mem_access a=%h sz=%0d wr=%b got rd=%0d wr=%0d", a, sz, wr, rd_cnt - r0, wr_cnt - w0);
    end
  endtask
  task automatic pipe_req(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    logic e;
    logic [31:0] exp;
    e = ref_err(sz, a);
    exp = (e || wr) ? 32'd0 : ref_load(sz, sg, a);
    drive(wr, sz, sg, a, d);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL pipe_ready got=%b exp=1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    if (!e && wr) ref_store(sz, a, d);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e || bus.rsp_rdata !== exp) begin
      failures++;
      $display("FAIL pipe_rsp a=%h sz=%0d wr=%b got v=%b e=%b d=%h exp v=1 e=%b d=%h",
               a, sz, wr, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e, exp);
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL in_reset ready=%b en=%b wr=%b valid=%b exp all 0", bus.req_ready, bus.mem_en, bus.mem_wr, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL after_reset ready=%b valid=%b err=%b rdata=%h en=%b", bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_en);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_loads;
    preload(8, 32'h8899AABB);
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'd0);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0);
  endtask
  task automatic test_byte_store;
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000CC);
    checks++;
    if (mem[8] !== 32'h88CCAABB) begin
      failures++;
      $display("FAIL byte_store got=%h exp=88ccaabb", mem[8]);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h26, 32'h00001234);
  endtask
  task automatic test_errors;
    do_req(1'b1, 2'd1, 1'b0, 32'h23, 32'h0000BEEF);
    do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678);
    do_req(1'b0, 2'd3, 1'b1, 32'h24, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h29, 32'hFFFFFFFF);
    check_mem("errors");
  endtask
  task automatic test_back_to_back;
    preload(8, 32'h8899AABB);
    preload(9, 32'h01234567);
    pipe_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    pipe_req(1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    pipe_req(1'b0, 2'd1, 1'b1, 32'h21, 32'd0);
    pipe_req(1'b0, 2'd0, 1'b1, 32'h25, 32'd0);
    bus.req_valid = 1'b0;
  endtask
  task automatic test_store_load;
    pipe_req(1'b1, 2'd2, 1'b0, 32'h24, 32'hDEADBEEF);
    pipe_req(1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_merge;
    preload(8, 32'h8899AABB);
    drive(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000BEEF);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_accept ready=%b exp=1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_in_reset en=%b valid=%b exp 0 0", bus.mem_en, bus.rsp_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mem[8] !== 32'h8899AABB) begin
      failures++;
      $display("FAIL rm_release ready=%b valid=%b mem=%h exp 1 0 8899aabb", bus.req_ready, bus.rsp_valid, mem[8]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_random;
    logic wr;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 60; i++)
      do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      a = $urandom;
      if (wr && sz != 2'd2 && !ref_err(sz, a)) begin
        sz = 2'd2;
        a[1:0] = 2'b00;
      end
      pipe_req(wr, sz, 1'($urandom), a, $urandom);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_mem("random");
    checks++;
    if (bad_bus != 0) begin
      failures++;
      $display("FAIL idle_bus got=%0d bad cycles exp=0", bad_bus);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_size = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_store_load();
    test_reset_merge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Load/store access stage between the pipeline's execute stage and the word-only, big-endian data memory. Accepts byte, halfword and word loads/stores, checks alignment, sign/zero-extends loads, and turns sub-word stores into a two-cycle read-modify-write, because the memory writes only whole aligned words. Memory read data is combinational and memory writes commit on the clock edge; this block drives the memory's `en/addr/wr/wdata` and consumes `rdata`.

## Interface
- No parameters; address/data width fixed at 32.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_wr` in 1: 1 store, 0 load.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 reserved.
- `req_signed` in 1: loads only, 1 sign-extend, 0 zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle pulse, request completed.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned or reserved-size request, valid with `rsp_valid`.
- `mem_en`, `mem_wr` out 1; `mem_addr`, `mem_wdata` out 32: to data memory.
- `mem_rdata` in 32: from data memory, combinational, valid same cycle as `mem_en && !mem_wr`.

## Operation
- States: IDLE, MERGE. `req_ready = (state == IDLE)`.
- Error check at accept: half with `addr[0]`, word with `addr[1:0] != 0`, or size 3 -> no memory access (`mem_en`=0); next cycle `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- Load (IDLE, accepted): `mem_en`=1, `mem_wr`=0, `mem_addr={addr[31:2],2'b00}` same cycle; lane extracted and extended, registered into `rsp_rdata`; `rsp_valid`=1 next cycle.
- Big-endian lanes: byte at `addr[1:0]`=0..3 -> `mem_rdata[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`; half at `addr[1]`=0 -> `[31:16]`, 1 -> `[15:0]`.
- Word store: `mem_en`=1, `mem_wr`=1, `mem_wdata=req_wdata` same cycle; `rsp_valid` next cycle.
- Sub-word store: accept cycle performs a read (`mem_wr`=0) and registers `mem_rdata`, addr, size and wdata. MERGE cycle drives `mem_en`=1, `mem_wr`=1, with `mem_wdata` = captured word with the target lane replaced. Then -> IDLE; `rsp_valid` the cycle after MERGE.
- `mem_*` outputs are combinational from state and request; when not accessing: `mem_en`=0, `mem_wr`=0, and addr/wdata are don't-care but held at 0.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, captured registers 0. While `rst_n`=0: `mem_en`=0, `mem_wr`=0, `req_ready`=0.
- Latency from accept to `rsp_valid`: load, word store and error = 1 cycle; sub-word store = 2 cycles.
- Throughput: loads, word stores and errors at 1 per cycle back-to-back. Sub-word stores hold `req_ready`=0 for exactly 1 cycle (MERGE).
- A request presented during MERGE is not accepted. The requester holds it stable until accepted.
- Reset during MERGE: the write is dropped (`mem_en` forced 0), memory is unchanged, no `rsp_valid`, and the block is in IDLE after release.
- `rsp_valid` is not back-pressured; the consumer always takes it.

## Structure
- Package `mem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state encodings, and a misalignment-check function.
- Sub-module `mem_lane_mux` (combinational): load extract/extend and store lane merge, from size, `addr[1:0]` and signed. Top level holds the FSM and registers.

## Test plan
- Preload `0x20`=`0x8899AABB`. Load byte signed at `0x20` -> `0xFFFFFF88`; byte unsigned at `0x23` -> `0x000000BB`; half signed at `0x22` -> `0xFFFFAABB`; each 1 cycle after accept.
- Byte store `0xCC` at `0x21` -> `req_ready` low 1 cycle, one read then one write, memory `0x20`=`0x88CCAABB`, `rsp_valid` 2 cycles after accept.
- Half store at `0x23` -> `rsp_err`=1 next cycle, `mem_en` never high, memory unchanged; size 3 gives the same response.
- Word loads `0x20`, `0x24` on consecutive cycles -> two consecutive `rsp_valid` with the correct data, `req_ready` stays 1.
- `rst_n`=0 in the MERGE cycle of a half store `0xBEEF` at `0x20` -> memory stays `0x8899AABB`, no `rsp_valid`, `req_ready`=1 the cycle after release.
- Word store `0xDEADBEEF` to `0x24` then word load `0x24` the next cycle -> load returns `0xDEADBEEF`.
